// File: rtl/mutex_arb_pkg.sv
// Shared types and width helpers for the mutex merge arbiter.
// Related build option: MUTEX_ARB_LOCK_EN (see mutex_merge_arbiter.sv).
package mutex_arb_pkg;

  typedef enum logic [1:0] {
    ARB_ROTATE,
    ARB_HOLD,
    ARB_LOCK
  } arb_hold_e;

  function automatic int unsigned grant_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int unsigned burst_w(input int unsigned max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/mutex_merge_arbiter_if.sv
// Requester/downstream channel bundle for the merge arbiter.
// i_lock exists only when MUTEX_ARB_LOCK_EN is defined.
interface mutex_merge_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
);
  import mutex_arb_pkg::*;

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]        i_drive;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_free;
  logic                      o_driveNext;
  logic [DATA_W-1:0]         o_data;
  logic [GRANT_W-1:0]        o_grant_id;
  logic                      i_freeNext;
`ifdef MUTEX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        i_lock;

  modport master (
    output i_drive, i_data, i_freeNext, i_lock,
    input  o_free, o_driveNext, o_data, o_grant_id
  );
  modport slave (
    input  i_drive, i_data, i_freeNext, i_lock,
    output o_free, o_driveNext, o_data, o_grant_id
  );
`else
  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_grant_id
  );
  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_grant_id
  );
`endif

endinterface

// File: rtl/mutex_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module mutex_rr_pick
  import mutex_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GRANT_W-1:0] i_start,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [GRANT_W-1:0] o_idx,
  output logic               o_any
);

  always_comb begin
    int unsigned pos;
    pos      = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = (32'(i_start) + i) % NUM_REQ;
      if (!o_any && i_req[GRANT_W'(pos)]) begin
        o_any = 1'b1;
        o_idx = GRANT_W'(pos);
      end
    end
    if (o_any) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mutex_merge_arbiter.sv
// N-to-1 round-robin merge arbiter with bounded bursts and a one-entry output register.
// Define MUTEX_ARB_LOCK_EN to add i_lock, which pins the grant across a locked sequence.
module mutex_merge_arbiter
  import mutex_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  mutex_merge_arbiter_if.slave bus
);

  localparam int unsigned GRANT_W = grant_w(NUM_REQ);
  localparam int unsigned BURST_W = burst_w(MAX_BURST);
  localparam logic [GRANT_W-1:0] LAST_IDX  = GRANT_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [GRANT_W-1:0] r_gid;
  logic [GRANT_W-1:0] r_last;
  logic [BURST_W-1:0] r_burst;

  logic               w_valid_d;
  logic [DATA_W-1:0]  w_data_d;
  logic [GRANT_W-1:0] w_gid_d;
  logic [GRANT_W-1:0] w_last_d;
  logic [BURST_W-1:0] w_burst_d;

  logic               w_locked;
  logic               w_can_load;
  logic               w_load;
  logic [GRANT_W-1:0] w_start;
  logic [NUM_REQ-1:0] w_rr_onehot;
  logic [GRANT_W-1:0] w_rr_idx;
  logic               w_rr_any;
  logic [GRANT_W-1:0] w_pick;
  logic [NUM_REQ-1:0] w_free;
  logic [DATA_W-1:0]  w_sel_data;
  arb_hold_e          w_hold_st;

`ifdef MUTEX_ARB_LOCK_EN
  logic r_lock;
  logic w_lock_d;

  always_ff @(posedge clk) begin
    if (!rst) r_lock <= 1'b0;
    else      r_lock <= w_lock_d;
  end

  always_comb begin
    w_lock_d = r_lock;
    if (w_load) w_lock_d = bus.i_lock[w_pick];
  end

  assign w_locked = r_lock;
`else
  assign w_locked = 1'b0;
`endif

  assign w_can_load = !r_valid || bus.i_freeNext;
  assign w_start    = (r_last == LAST_IDX) ? '0 : r_last + GRANT_W'(1);
  assign w_load     = |w_free;
  assign w_sel_data = bus.i_data[w_pick*DATA_W +: DATA_W];

  mutex_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .i_req    (bus.i_drive),
    .i_start  (w_start),
    .o_onehot (w_rr_onehot),
    .o_idx    (w_rr_idx),
    .o_any    (w_rr_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
      r_last  <= LAST_IDX;
      r_burst <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_gid   <= w_gid_d;
      r_last  <= w_last_d;
      r_burst <= w_burst_d;
    end
  end

  // burst_cnt==0 means "nothing granted since reset", so it never holds.
  always_comb begin
    w_hold_st = ARB_ROTATE;
    if (w_locked) begin
      w_hold_st = ARB_LOCK;
    end else if (bus.i_drive[r_last] && (r_burst != '0) && (r_burst < BURST_MAX)) begin
      w_hold_st = ARB_HOLD;
    end
  end

  always_comb begin
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_gid_d   = r_gid;
    w_last_d  = r_last;
    w_burst_d = r_burst;
    if (w_load) begin
      w_valid_d = 1'b1;
      w_data_d  = w_sel_data;
      w_gid_d   = w_pick;
      w_last_d  = w_pick;
      if (w_pick == r_last) begin
        w_burst_d = (r_burst >= BURST_MAX) ? BURST_MAX : r_burst + BURST_W'(1);
      end else begin
        w_burst_d = BURST_W'(1);
      end
    end else if (bus.i_freeNext) begin
      w_valid_d = 1'b0;
    end
  end

  always_comb begin
    w_pick = r_last;
    w_free = '0;
    unique case (w_hold_st)
      ARB_ROTATE: begin
        w_pick = w_rr_idx;
        if (w_rr_any) w_free = w_rr_onehot;
      end
      ARB_HOLD, ARB_LOCK: w_free[r_last] = bus.i_drive[r_last];
      default: w_free = '0;
    endcase
    if (!(w_can_load && rst)) w_free = '0;
  end

  assign bus.o_free      = w_free;
  assign bus.o_driveNext = r_valid;
  assign bus.o_data      = r_data;
  assign bus.o_grant_id  = r_gid;

endmodule

// File: tb/tb_mutex_merge_arbiter.sv
// Directed bench for mutex_merge_arbiter with a per-cycle reference model and beat scoreboard.
module tb_mutex_merge_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 4;

  logic clk;
  logic rst;

  mutex_merge_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  mutex_merge_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic              lk0[$];
  logic              lk1[$];
  logic              fnext;
  logic [32:0]       got[$];
  logic [32:0]       exp_q[$];
  logic [NUM_REQ-1:0] last_free;
  logic [DATA_W-1:0] last_data;

  // Reference model state
  bit                m_ok = 1'b0;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_gid;
  int                m_last;
  int                m_cnt;
  bit                m_lock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply();
    bus.i_drive[0] = (q0.size() > 0);
    bus.i_drive[1] = (q1.size() > 0);
    bus.i_data[0*DATA_W +: DATA_W] = (q0.size() > 0) ? q0[0] : '0;
    bus.i_data[1*DATA_W +: DATA_W] = (q1.size() > 0) ? q1[0] : '0;
`ifdef MUTEX_ARB_LOCK_EN
    bus.i_lock[0] = (lk0.size() > 0) ? lk0[0] : 1'b0;
    bus.i_lock[1] = (lk1.size() > 0) ? lk1[0] : 1'b0;
`endif
    bus.i_freeNext = fnext;
  endtask

  // Compare DUT against the model, then advance the model to the next edge.
  task automatic model_check();
    int win;
    int c;
    logic [NUM_REQ-1:0] exp_free;
    if (!rst) begin
      chk("free_in_reset", 64'(bus.o_free), 64'(0));
      m_ok = 1'b1; m_valid = 1'b0; m_data = '0; m_gid = 0;
      m_last = NUM_REQ - 1; m_cnt = 0; m_lock = 1'b0;
    end else if (m_ok) begin
      win = -1;
      if (!m_valid || fnext) begin
        if (m_lock) begin
          if (bus.i_drive[m_last]) win = m_last;
        end else if (bus.i_drive[m_last] && m_cnt > 0 && m_cnt < MAX_BURST) begin
          win = m_last;
        end else begin
          for (int s = 1; s <= NUM_REQ; s++) begin
            c = (m_last + s) % NUM_REQ;
            if (win < 0 && bus.i_drive[c]) win = c;
          end
        end
      end
      exp_free = '0;
      if (win >= 0) exp_free[win] = 1'b1;
      chk("o_free", 64'(bus.o_free), 64'(exp_free));
      chk("o_driveNext", 64'(bus.o_driveNext), 64'(m_valid));
      chk("o_data", 64'(bus.o_data), 64'(m_data));
      chk("o_grant_id", 64'(bus.o_grant_id), 64'(m_gid));
      if (bus.o_driveNext && fnext) got.push_back({bus.o_grant_id, bus.o_data});
      if (win >= 0) begin
        m_cnt = (win == m_last) ? ((m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1) : 1;
        m_last = win;
        m_gid = win;
        m_data = bus.i_data[win*DATA_W +: DATA_W];
        m_valid = 1'b1;
`ifdef MUTEX_ARB_LOCK_EN
        m_lock = bus.i_lock[win];
`endif
      end else if (fnext) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    apply();
    @(negedge clk);
    model_check();
    last_free = bus.o_free;
    last_data = bus.o_data;
    @(posedge clk);
    #1;
    if (last_free[0] && q0.size() > 0) begin
      void'(q0.pop_front());
      if (lk0.size() > 0) void'(lk0.pop_front());
    end
    if (last_free[1] && q1.size() > 0) begin
      void'(q1.pop_front());
      if (lk1.size() > 0) void'(lk1.pop_front());
    end
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); lk0.delete(); lk1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_q();
    fnext = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    bit busy;
    k = 0;
    busy = (q0.size() > 0) || (q1.size() > 0) || bus.o_driveNext;
    while (busy && k < budget) begin
      tick();
      k++;
      busy = (q0.size() > 0) || (q1.size() > 0) || bus.o_driveNext;
    end
    chk({name, "_drain_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic check_seq(input string name);
    int n;
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  function automatic logic [32:0] beat(input logic id, input logic [31:0] d);
    return {id, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    fnext = 1'b1;
    bus.i_drive = '0;
    bus.i_data = '0;
    bus.i_freeNext = 1'b1;
`ifdef MUTEX_ARB_LOCK_EN
    bus.i_lock = '0;
`endif

    // Reset with both requesters asserted
    q0.push_back(32'h11); q1.push_back(32'h22);
    tick();
    tick();
    chk("rst_free", 64'(last_free), 64'(0));
    chk("rst_driveNext", 64'(bus.o_driveNext), 64'(0));
    chk("rst_data", 64'(bus.o_data), 64'(0));
    chk("rst_gid", 64'(bus.o_grant_id), 64'(0));
    clear_q();
    rst = 1'b1;

    // Lone stream from req0
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(32'(i));
      exp_q.push_back(beat(1'b0, 32'(i)));
    end
    drain("lone", 40);
    check_seq("lone");

    // Contention: bursts of four alternate
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'hA0 + 32'(i));
      q1.push_back(32'hB0 + 32'(i));
    end
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(beat(g[0], ((g[0] ? 32'hB0 : 32'hA0) + 32'((g / 2) * 4 + i))));
      end
    end
    drain("contend", 60);
    check_seq("contend");

    // Backpressure: register holds C1 through a 3-cycle stall
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q1.push_back(32'hC0 + 32'(i));
      exp_q.push_back(beat(1'b1, 32'hC0 + 32'(i)));
    end
    tick();
    tick();
    fnext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_free", 64'(last_free), 64'(0));
      chk("stall_data", 64'(last_data), 64'(32'hC1));
    end
    fnext = 1'b1;
    drain("bp", 40);
    check_seq("bp");

    // Drain and load on the same edge
    do_reset();
    q0.push_back(32'hD0); q1.push_back(32'hE0);
    exp_q.push_back(beat(1'b0, 32'hD0)); exp_q.push_back(beat(1'b1, 32'hE0));
    tick();
    tick();
    chk("dl_free", 64'(last_free), 64'(2'b10));
    chk("dl_driveNext", 64'(bus.o_driveNext), 64'(1));
    chk("dl_data", 64'(bus.o_data), 64'(32'hE0));
    chk("dl_gid", 64'(bus.o_grant_id), 64'(1));
    drain("dl", 20);
    check_seq("dl");

    // Reset while a beat is buffered
    do_reset();
    fnext = 1'b0;
    q0.push_back(32'h55);
    tick();
    chk("mid_loaded", 64'(bus.o_driveNext), 64'(1));
    do_reset();
    chk("mid_discard", 64'(bus.o_driveNext), 64'(0));
    chk("mid_data", 64'(bus.o_data), 64'(0));

    // Locked sequence from req0 while req1 waits
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(32'hF0 + 32'(i));
      lk0.push_back(i != 5);
    end
    q1.push_back(32'h10); q1.push_back(32'h11);
    lk1.push_back(1'b0); lk1.push_back(1'b0);
`ifdef MUTEX_ARB_LOCK_EN
    for (int i = 0; i < 6; i++) exp_q.push_back(beat(1'b0, 32'hF0 + 32'(i)));
    exp_q.push_back(beat(1'b1, 32'h10)); exp_q.push_back(beat(1'b1, 32'h11));
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(beat(1'b0, 32'hF0 + 32'(i)));
    exp_q.push_back(beat(1'b1, 32'h10)); exp_q.push_back(beat(1'b1, 32'h11));
    exp_q.push_back(beat(1'b0, 32'hF4)); exp_q.push_back(beat(1'b0, 32'hF5));
`endif
    drain("lock", 40);
    check_seq("lock");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
